// File: rtl/reg8_serial_tx.sv
// Parallel-in, bit-serial-out transmitter: start bit, WIDTH data bits LSB first, stop bit.
// Define SERTX_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module reg8_serial_tx #(
  parameter int WIDTH = 8,
  parameter int DIV   = 4
) (
  input  logic             CK,
  input  logic             CLR,
  input  logic [WIDTH-1:0] D,
  input  logic             START,
  output logic             TXD,
  output logic             BUSY,
  output logic             DONE
);

  localparam int DIVW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int BITW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [DIVW-1:0] DIV_LAST    = DIVW'(DIV - 1);
  localparam logic [DIVW-1:0] DIV_PRELAST = DIVW'(DIV - 2);
  localparam logic [BITW-1:0] BIT_LAST    = BITW'(WIDTH - 1);
  // With one cycle per bit the first stop cycle is also the last, so DONE rises on entry.
  localparam logic DONE_ON_ENTRY = (DIV == 1) ? 1'b1 : 1'b0;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
`ifdef SERTX_PARITY_EN
    S_PARITY = 3'd3,
`endif
    S_STOP   = 3'd4
  } state_t;

  state_t            state_q;
  logic [DIVW-1:0]   div_q;
  logic [BITW-1:0]   bit_q;
  logic [WIDTH-1:0]  sh_q;
  logic              txd_q;
  logic              busy_q;
  logic              done_q;
`ifdef SERTX_PARITY_EN
  logic              par_q;
`endif

  logic [WIDTH-1:0]  sh_d;
  logic [DIVW-1:0]   div_d;
  logic              div_end_s;

  // Next shift value, incremented divider and end-of-bit-time flag.
  always_comb begin
    sh_d      = sh_q >> 1;
    div_d     = div_q + DIVW'(1);
    div_end_s = (div_q == DIV_LAST);
  end

  // Frame sequencer; every output is taken straight from a register.
  always_ff @(posedge CK or negedge CLR) begin
    if (!CLR) begin
      state_q <= S_IDLE;
      div_q   <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      txd_q   <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef SERTX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          div_q  <= '0;
          bit_q  <= '0;
          if (START) begin
            sh_q    <= D;
`ifdef SERTX_PARITY_EN
            par_q   <= ^D;
`endif
            state_q <= S_START;
            txd_q   <= 1'b0;
            busy_q  <= 1'b1;
          end else begin
            txd_q   <= 1'b1;
            busy_q  <= 1'b0;
          end
        end
        S_START: begin
          if (div_end_s) begin
            div_q   <= '0;
            state_q <= S_DATA;
            txd_q   <= sh_q[0];
          end else begin
            div_q   <= div_d;
          end
        end
        S_DATA: begin
          if (div_end_s) begin
            div_q <= '0;
            sh_q  <= sh_d;
            if (bit_q == BIT_LAST) begin
              bit_q   <= '0;
`ifdef SERTX_PARITY_EN
              state_q <= S_PARITY;
              txd_q   <= par_q;
`else
              state_q <= S_STOP;
              txd_q   <= 1'b1;
              done_q  <= DONE_ON_ENTRY;
`endif
            end else begin
              bit_q   <= bit_q + BITW'(1);
              txd_q   <= sh_d[0];
            end
          end else begin
            div_q <= div_d;
          end
        end
`ifdef SERTX_PARITY_EN
        S_PARITY: begin
          if (div_end_s) begin
            div_q   <= '0;
            state_q <= S_STOP;
            txd_q   <= 1'b1;
            done_q  <= DONE_ON_ENTRY;
          end else begin
            div_q   <= div_d;
          end
        end
`endif
        S_STOP: begin
          if (div_end_s) begin
            div_q   <= '0;
            state_q <= S_IDLE;
            txd_q   <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
          end else begin
            div_q   <= div_d;
            done_q  <= (div_q == DIV_PRELAST);
          end
        end
        default: begin
          state_q <= S_IDLE;
          div_q   <= '0;
          bit_q   <= '0;
          txd_q   <= 1'b1;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign TXD  = txd_q;
  assign BUSY = busy_q;
  assign DONE = done_q;

endmodule

// File: tb/tb_reg8_serial_tx.sv
// Bench for reg8_serial_tx: an 8-bit/DIV=4 instance and a 16-bit/DIV=1 instance,
// each checked frame-by-frame against a bit-list model through per-channel scoreboards.
module tb_reg8_serial_tx;

  localparam int W0 = 8;
  localparam int V0 = 4;
  localparam int W1 = 16;
  localparam int V1 = 1;
`ifdef SERTX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int L0 = (W0 + 2 + PAR) * V0;
  localparam int L1 = (W1 + 2 + PAR) * V1;

  logic        ck = 1'b0;
  logic        clr;
  logic        start0, start1;
  logic [7:0]  d0;
  logic [15:0] d1;
  logic        txd0, busy0, done0, txd1, busy1, done1;
  logic [1:0]  txd_s, busy_s, done_s;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [63:0] bits;
    int          nbits;
    int          div;
  } frame_t;

  frame_t exp_q0[$];
  frame_t exp_q1[$];

  logic [127:0] cap_txd  [2];
  logic [127:0] cap_done [2];
  int           cap_len  [2];
  logic         active   [2];

  always #5 ck = ~ck;

  reg8_serial_tx #(.WIDTH(W0), .DIV(V0)) u_dut8 (
    .CK(ck), .CLR(clr), .D(d0), .START(start0), .TXD(txd0), .BUSY(busy0), .DONE(done0)
  );
  reg8_serial_tx #(.WIDTH(W1), .DIV(V1)) u_dut16 (
    .CK(ck), .CLR(clr), .D(d1), .START(start1), .TXD(txd1), .BUSY(busy1), .DONE(done1)
  );

  assign txd_s  = {txd1, txd0};
  assign busy_s = {busy1, busy0};
  assign done_s = {done1, done0};

  // Reference frame: list of line levels, one per bit time.
  function automatic frame_t make_frame(logic [31:0] d, int w, int div);
    frame_t f;
    logic   p;
    f.bits = '0;
    f.div  = div;
    p      = 1'b0;
    f.bits[0] = 1'b0;
    for (int i = 0; i < w; i++) begin
      f.bits[1 + i] = d[i];
      p = p ^ d[i];
    end
    f.nbits = w + 1;
    if (PAR != 0) begin
      f.bits[f.nbits] = p;
      f.nbits++;
    end
    f.bits[f.nbits] = 1'b1;
    f.nbits++;
    return f;
  endfunction

  task automatic check(string name, logic [127:0] act, logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic end_frame(int ch, int len, logic [127:0] ct, logic [127:0] cd);
    frame_t       f;
    int           bad;
    logic [127:0] mask, dexp;
    if ((ch == 0 && exp_q0.size() == 0) || (ch == 1 && exp_q1.size() == 0)) begin
      checks++;
      errors++;
      $display("FAIL unexpected_frame_ch%0d: got frame of %0d cycles, expected none", ch, len);
      return;
    end
    if (ch == 0) f = exp_q0.pop_front();
    else         f = exp_q1.pop_front();
    check($sformatf("frame_len_ch%0d", ch), len, f.nbits * f.div);
    bad = 0;
    for (int c = 0; c < len && c < 128; c++) begin
      if (bad == 0 && ((c / f.div) > 63 || ct[c] !== f.bits[(c / f.div) % 64])) bad = c + 1;
    end
    check($sformatf("txd_first_bad_cycle_ch%0d", ch), bad, 0);
    mask = (len >= 128) ? '1 : ((128'd1 << len) - 128'd1);
    dexp = 128'd1 << (f.nbits * f.div - 1);
    check($sformatf("done_cycles_ch%0d", ch), cd & mask, dexp);
  endtask

  // Monitor: captures each frame while BUSY is high, scores it when BUSY drops.
  always @(negedge ck) begin
    for (int ch = 0; ch < 2; ch++) begin
      if (!clr) begin
        cap_len[ch] <= 0;
        active[ch]  <= 1'b0;
      end else if (busy_s[ch]) begin
        if (cap_len[ch] < 128) begin
          cap_txd[ch][cap_len[ch][6:0]]  <= txd_s[ch];
          cap_done[ch][cap_len[ch][6:0]] <= done_s[ch];
        end
        cap_len[ch] <= cap_len[ch] + 1;
        active[ch]  <= 1'b1;
      end else begin
        check($sformatf("idle_line_done_ch%0d", ch), {txd_s[ch], done_s[ch]}, 2'b10);
        if (active[ch]) end_frame(ch, cap_len[ch], cap_txd[ch], cap_done[ch]);
        active[ch]  <= 1'b0;
        cap_len[ch] <= 0;
      end
    end
  end

  task automatic wait_idle(int ch);
    int n;
    n = 0;
    while (((ch == 0) ? busy0 : busy1) !== 1'b0 && n < 500) begin
      @(negedge ck);
      n++;
    end
    if (n >= 500) begin
      checks++;
      errors++;
      $display("FAIL wait_idle_ch%0d: BUSY still 1 after %0d cycles, expected 0", ch, n);
    end
  endtask

  // Returns one cycle after the accepting edge (inside frame cycle 1).
  task automatic send(int ch, logic [15:0] d, bit push);
    @(negedge ck);
    wait_idle(ch);
    if (ch == 0) begin
      d0 = d[7:0];
      start0 = 1'b1;
    end else begin
      d1 = d;
      start1 = 1'b1;
    end
    @(posedge ck);
    #1;
    if (ch == 0) start0 = 1'b0;
    else         start1 = 1'b0;
    if (push) begin
      if (ch == 0) exp_q0.push_back(make_frame({16'h0, d}, W0, V0));
      else         exp_q1.push_back(make_frame({16'h0, d}, W1, V1));
    end
  endtask

  initial begin
    int          cur;
    int          k;
    logic [63:0] got, want;
    start0 = 1'b0;
    start1 = 1'b0;
    d0     = 8'h00;
    d1     = 16'h0000;
    clr    = 1'b1;
    #1 clr = 1'b0;
    #2;
    check("reset_ch0", {txd0, busy0, done0}, 3'b100);
    check("reset_ch1", {txd1, busy1, done1}, 3'b100);
    @(negedge ck);
    @(negedge ck);
    clr = 1'b1;

    // Single frames, including the parity values for A5 and 01.
    send(0, 16'h00A5, 1'b1);
    send(0, 16'h0001, 1'b1);

    // Re-pulsed START during a frame, the last one in the DONE cycle.
    send(0, 16'h003C, 1'b1);
    cur = 1;
    for (int i = 0; i < 3; i++) begin
      k = (i == 0) ? 5 : ((i == 1) ? 20 : L0);
      repeat (k - cur) @(posedge ck);
      #1;
      if (k == L0) check("done_in_last_cycle", done0, 1'b1);
      d0 = 8'hFF;
      start0 = 1'b1;
      @(posedge ck);
      #1;
      start0 = 1'b0;
      cur = k + 1;
    end
    check("busy_after_ignored_start", busy0, 1'b0);
    repeat (3) @(negedge ck);
    check("no_second_frame", busy0, 1'b0);

    // Asynchronous abort in frame cycle 17.
    send(0, 16'h0000, 1'b0);
    repeat (16) @(posedge ck);
    #1;
    check("pre_abort_txd_busy", {txd0, busy0}, 2'b01);
    #1 clr = 1'b0;
    #1;
    check("abort_outputs", {txd0, busy0, done0}, 3'b100);
    @(negedge ck);
    #2 clr = 1'b1;
    send(0, 16'h0081, 1'b1);

    // START held high on the DIV=1 instance: back-to-back frames with one idle cycle.
    @(negedge ck);
    wait_idle(1);
    d1 = 16'h8001;
    start1 = 1'b1;
    @(posedge ck);
    exp_q1.push_back(make_frame(32'h8001, W1, V1));
    exp_q1.push_back(make_frame(32'h8001, W1, V1));
    got  = '0;
    want = '0;
    for (int i = 1; i <= 2 * L1 + 1; i++) begin
      @(negedge ck);
      got[i]  = busy1;
      want[i] = (i != L1 + 1);
      if (i == L1 + 3) start1 = 1'b0;
    end
    check("held_start_busy_pattern", got, want);

    // Random words on both channels, overlapping in time.
    for (int n = 0; n < 16; n++) begin
      int   ch;
      logic [31:0] r;
      ch = $urandom_range(0, 1);
      r  = $urandom;
      repeat ($urandom_range(0, 3)) @(negedge ck);
      send(ch, r[15:0], 1'b1);
    end

    @(negedge ck);
    wait_idle(0);
    wait_idle(1);
    repeat (3) @(negedge ck);
    check("pending_frames", exp_q0.size() + exp_q1.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
